// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: command codes, ALU op codes, FSM states.
package alu_seq_pkg;

    localparam logic [3:0] SEQ_ADD = 4'd0;
    localparam logic [3:0] SEQ_SUB = 4'd1;
    localparam logic [3:0] SEQ_ASL = 4'd2;
    localparam logic [3:0] SEQ_ROL = 4'd3;
    localparam logic [3:0] SEQ_LSR = 4'd4;
    localparam logic [3:0] SEQ_ROR = 4'd5;
    localparam logic [3:0] SEQ_AND = 4'd6;
    localparam logic [3:0] SEQ_ORA = 4'd7;
    localparam logic [3:0] SEQ_EOR = 4'd8;

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0111;
    localparam logic [3:0] ALU_SHL = 4'b1011;
    localparam logic [3:0] ALU_SHR = 4'b1111;
    localparam logic [3:0] ALU_ORA = 4'b1100;
    localparam logic [3:0] ALU_AND = 4'b1101;
    localparam logic [3:0] ALU_EOR = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } seq_state_t;

    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        case (op)
            SEQ_ADD:          alu_op_of = ALU_ADD;
            SEQ_SUB:          alu_op_of = ALU_SUB;
            SEQ_ASL, SEQ_ROL: alu_op_of = ALU_SHL;
            SEQ_LSR, SEQ_ROR: alu_op_of = ALU_SHR;
            SEQ_AND:          alu_op_of = ALU_AND;
            SEQ_EOR:          alu_op_of = ALU_EOR;
            default:          alu_op_of = ALU_ORA;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-byte arithmetic sequencer: feeds the 8-bit ALU one byte per cycle, chains carry
// through the ALU's registered CO and assembles the result and final flags.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// ISSUE   | presenting byte idx to the ALU, capturing the previous byte's result
// CAPTURE | storing the last byte and computing final flags, done next cycle
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RDY,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic                  cmd_ci,
    input  logic                  cmd_bcd,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    output logic [3:0]            alu_op,
    output logic                  alu_right,
    output logic                  alu_bcd,
    output logic                  alu_ci,
    output logic [7:0]            alu_ai,
    output logic [7:0]            alu_bi,
    input  logic [7:0]            alu_out,
    input  logic                  alu_co,
    input  logic                  alu_v,
    input  logic                  alu_n,
    output logic                  done,
    output logic [8*NBYTES-1:0]   res,
    output logic                  res_c,
    output logic                  res_z,
    output logic                  res_n,
    output logic                  res_v
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    seq_state_t      state;
    logic [IW-1:0]   idx;
    logic [3:0]      op_q;
    logic            ci_q;
    logic            bcd_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic [7:0]      a_byte [NBYTES];
    logic [7:0]      b_byte [NBYTES];
    logic [W-1:0]    res_next;
    logic            is_arith;
    logic            is_shift;
    logic            msb_first;
    logic [IW-1:0]   cur_k;
    logic [IW-1:0]   prev_k;
    logic [IW-1:0]   wr_slot;
    logic            wr_en;

    assign is_arith  = (op_q == SEQ_ADD) || (op_q == SEQ_SUB);
    assign msb_first = (op_q == SEQ_LSR) || (op_q == SEQ_ROR);
    assign is_shift  = msb_first || (op_q == SEQ_ASL) || (op_q == SEQ_ROL);

    // Right shifts walk MSB-first so the carry flows downward through the bytes.
    assign cur_k   = msb_first ? (LAST - idx) : idx;
    assign prev_k  = msb_first ? (cur_k + IW'(1)) : (cur_k - IW'(1));
    assign wr_en   = ((state == ISSUE) && (idx != '0)) || (state == CAPTURE);
    assign wr_slot = (state == CAPTURE) ? cur_k : prev_k;

    assign cmd_ready = (state == IDLE);

    for (genvar g = 0; g < NBYTES; g++) begin : g_slot
        assign a_byte[g] = a_q[8*g +: 8];
        assign b_byte[g] = b_q[8*g +: 8];
        assign res_next[8*g +: 8] = (wr_en && (wr_slot == IW'(g))) ? alu_out : res[8*g +: 8];
    end

    // ALU inputs decode straight from registered state; alu_ci must see the live CO.
    always_comb begin
        alu_op    = '0;
        alu_right = 1'b0;
        alu_bcd   = 1'b0;
        alu_ci    = 1'b0;
        alu_ai    = '0;
        alu_bi    = '0;
        if (state == ISSUE) begin
            alu_op    = alu_op_of(op_q);
            alu_right = msb_first;
            alu_bcd   = bcd_q & is_arith;
            alu_ai    = a_byte[cur_k];
            alu_bi    = is_shift ? 8'h00 : b_byte[cur_k];
            if (idx == '0)
                alu_ci = ((op_q == SEQ_ASL) || (op_q == SEQ_LSR)) ? 1'b0 : ci_q;
            else
                alu_ci = alu_co;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            op_q  <= '0;
            ci_q  <= 1'b0;
            bcd_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            res_c <= 1'b0;
            res_z <= 1'b0;
            res_n <= 1'b0;
            res_v <= 1'b0;
            done  <= 1'b0;
        end else if (RDY) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        ci_q  <= cmd_ci;
                        bcd_q <= cmd_bcd;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    res <= res_next;
                    if (idx == LAST)
                        state <= CAPTURE;
                    else
                        idx <= idx + IW'(1);
                end
                CAPTURE: begin
                    res   <= res_next;
                    res_c <= alu_co;
                    res_v <= is_arith & alu_v;
                    // LSB-first ops finish on the top byte, whose N the ALU already holds.
                    res_n <= msb_first ? res_next[W-1] : alu_n;
                    res_z <= ~|res_next;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural 8-bit ALU; full-width reference model feeds a scoreboard.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int NBYTES = 2;
    localparam int W = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         RDY = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic         cmd_ci = 1'b0;
    logic         cmd_bcd = 1'b0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [3:0]   alu_op;
    logic         alu_right, alu_bcd, alu_ci;
    logic [7:0]   alu_ai, alu_bi;
    logic [7:0]   alu_out;
    logic         alu_co, alu_v, alu_n;
    logic         done;
    logic [W-1:0] res;
    logic         res_c, res_z, res_n, res_v;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ci(cmd_ci), .cmd_bcd(cmd_bcd), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_right(alu_right), .alu_bcd(alu_bcd), .alu_ci(alu_ci),
        .alu_ai(alu_ai), .alu_bi(alu_bi),
        .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v), .alu_n(alu_n),
        .done(done), .res(res), .res_c(res_c), .res_z(res_z), .res_n(res_n), .res_v(res_v)
    );

    // Behavioural core ALU: registered result and flags, frozen when RDY is low.
    logic [7:0] m_lg, m_bb, m_out;
    logic [8:0] m_sum;
    logic [4:0] m_lo, m_hi;
    logic       m_cin, m_co, m_v, m_hc, m_shout;

    always_comb begin
        m_lg = '0; m_bb = '0; m_out = '0; m_sum = '0; m_lo = '0; m_hi = '0;
        m_cin = 1'b0; m_co = 1'b0; m_v = 1'b0; m_hc = 1'b0; m_shout = 1'b0;
        case (alu_op[1:0])
            2'b00: m_lg = alu_ai | alu_bi;
            2'b01: m_lg = alu_ai & alu_bi;
            2'b10: m_lg = alu_ai ^ alu_bi;
            default: m_lg = alu_ai;
        endcase
        m_shout = m_lg[0];
        if (alu_right) m_lg = {alu_ci, m_lg[7:1]};
        case (alu_op[3:2])
            2'b00: m_bb = alu_bi;
            2'b01: m_bb = ~alu_bi;
            2'b10: m_bb = m_lg;
            default: m_bb = 8'h00;
        endcase
        m_cin = (alu_right || (alu_op[3:2] == 2'b11)) ? 1'b0 : alu_ci;
        m_sum = {1'b0, m_lg} + {1'b0, m_bb} + 9'(m_cin);
        m_out = m_sum[7:0];
        m_co  = alu_right ? m_shout : m_sum[8];
        m_v   = (m_lg[7] == m_bb[7]) && (m_sum[7] != m_lg[7]);
        m_lo  = {1'b0, m_lg[3:0]} + {1'b0, m_bb[3:0]} + 5'(m_cin);
        if (alu_bcd && (alu_op[3:2] == 2'b00)) begin
            m_hc = (m_lo > 5'd9);
            if (m_hc) m_lo = m_lo + 5'd6;
            m_hi = {1'b0, m_lg[7:4]} + {1'b0, m_bb[7:4]} + 5'(m_hc);
            m_co = (m_hi > 5'd9);
            if (m_co) m_hi = m_hi + 5'd6;
            m_out = {m_hi[3:0], m_lo[3:0]};
        end else if (alu_bcd && (alu_op[3:2] == 2'b01)) begin
            m_hc = m_lo[4];
            if (!m_hc) m_lo = m_lo - 5'd6;
            m_hi = {1'b0, m_lg[7:4]} + {1'b0, m_bb[7:4]} + 5'(m_hc);
            m_co = m_hi[4];
            if (!m_co) m_hi = m_hi - 5'd6;
            m_out = {m_hi[3:0], m_lo[3:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_out <= '0; alu_co <= 1'b0; alu_v <= 1'b0; alu_n <= 1'b0;
        end else if (RDY) begin
            alu_out <= m_out; alu_co <= m_co; alu_v <= m_v; alu_n <= m_out[7];
        end
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic c, z, n, v, chk_v;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t ref_model(input logic [3:0] op, input logic ci, input logic bcd,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        int d, carry;
        e = '0;
        e.chk_v = 1'b1;
        s = '0;
        case (op)
            SEQ_ADD: begin
                if (bcd) begin
                    carry = int'(ci);
                    for (int i = 0; i < W/4; i++) begin
                        d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + carry;
                        if (d > 9) begin d = d - 10; carry = 1; end
                        else carry = 0;
                        e.res[4*i +: 4] = d[3:0];
                    end
                    e.c = (carry != 0);
                    e.chk_v = 1'b0;
                end else begin
                    s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                    e.res = s[W-1:0];
                    e.c = s[W];
                    e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
                end
            end
            SEQ_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci);
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            SEQ_ASL: begin e.res = {a[W-2:0], 1'b0}; e.c = a[W-1]; end
            SEQ_ROL: begin e.res = {a[W-2:0], ci};   e.c = a[W-1]; end
            SEQ_LSR: begin e.res = {1'b0, a[W-1:1]}; e.c = a[0]; end
            SEQ_ROR: begin e.res = {ci, a[W-1:1]};   e.c = a[0]; end
            SEQ_AND: e.res = a & b;
            SEQ_EOR: e.res = a ^ b;
            default: e.res = a | b;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic ci, input logic bcd,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit poke);
        int t_acc;
        bit seen;
        exp_t e;
        check({tag, " ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_ci = ci; cmd_bcd = bcd; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        cmd_valid = 1'b0;
        sb.push_back(ref_model(op, ci, bcd, a, b));
        check({tag, " ready_busy"}, 32'(cmd_ready), 32'd0);
        if (poke) begin
            cmd_valid = 1'b1; cmd_op = SEQ_AND; cmd_a = ~a; cmd_b = 16'h1234;
        end
        if (stall > 0) begin
            RDY = 1'b0;
            repeat (stall) @(posedge clk);
            #1 RDY = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " latency"}, 32'(cyc - t_acc), 32'(NBYTES + 1 + stall));
            check({tag, " res"}, 32'(res), 32'(e.res));
            check({tag, " c"}, 32'(res_c), 32'(e.c));
            check({tag, " z"}, 32'(res_z), 32'(e.z));
            check({tag, " n"}, 32'(res_n), 32'(e.n));
            if (e.chk_v) check({tag, " v"}, 32'(res_v), 32'(e.v));
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 32'(done), 32'd0);
            check({tag, " res_held"}, 32'(res), 32'(e.res));
        end
    endtask

    initial begin
        bit seen_done;
        logic [3:0] rop;
        repeat (2) @(posedge clk);
        #1;
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst res", 32'(res), 32'd0);
        check("rst flags", 32'({res_c, res_z, res_n, res_v}), 32'd0);
        check("rst alu_ctl", 32'({alu_op, alu_right, alu_bcd, alu_ci}), 32'd0);
        check("rst alu_data", 32'({alu_ai, alu_bi}), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        run_cmd("add_carry", SEQ_ADD, 1'b0, 1'b0, 16'h12FF, 16'h0001, 0, 1'b0);
        run_cmd("sub_borrow", SEQ_SUB, 1'b1, 1'b0, 16'h0000, 16'h0001, 0, 1'b0);
        run_cmd("add_ovf", SEQ_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 0, 1'b0);
        run_cmd("ror", SEQ_ROR, 1'b1, 1'b0, 16'h0001, 16'hFFFF, 0, 1'b0);
        run_cmd("lsr", SEQ_LSR, 1'b0, 1'b0, 16'h0100, 16'h0000, 0, 1'b0);
        run_cmd("bcd_add", SEQ_ADD, 1'b0, 1'b1, 16'h0999, 16'h0001, 0, 1'b0);
        run_cmd("eor_zero_poke", SEQ_EOR, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5, 0, 1'b1);
        run_cmd("asl", SEQ_ASL, 1'b1, 1'b0, 16'h8001, 16'h0000, 0, 1'b0);
        run_cmd("rol", SEQ_ROL, 1'b1, 1'b0, 16'h4080, 16'h0000, 0, 1'b0);
        run_cmd("and", SEQ_AND, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 0, 1'b0);
        run_cmd("ora", SEQ_ORA, 1'b0, 1'b0, 16'h8000, 16'h0003, 0, 1'b0);
        run_cmd("add_stall", SEQ_ADD, 1'b0, 1'b0, 16'h12FF, 16'h0001, 3, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rop = 4'($urandom_range(0, 8));
            run_cmd("random", rop, 1'($urandom_range(0, 1)), 1'b0,
                    16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // Async reset while the sequencer is between bytes.
        run_cmd("pre_reset", SEQ_ADD, 1'b0, 1'b0, 16'h1111, 16'h2222, 0, 1'b0);
        cmd_op = SEQ_ADD; cmd_ci = 1'b0; cmd_bcd = 1'b0; cmd_a = 16'h00FF; cmd_b = 16'h0001;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst done", 32'(done), 32'd0);
        check("midrst res", 32'(res), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("midrst no_done", 32'(seen_done), 32'd0);
        run_cmd("post_reset", SEQ_SUB, 1'b1, 1'b0, 16'h1000, 16'h0001, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
